// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared FSM encoding, opcodes and default width for the add/sub arbiter
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/addsub_unit.sv
// rtl/addsub_unit.sv - combinational WIDTH-bit add/sub with carry/borrow flag
//   i_sel    : OP_ADD (a+b) or OP_SUB (a-b)
//   i_a, i_b : unsigned operands
//   o_result : result modulo 2^WIDTH
//   o_flag   : carry-out for add, borrow (a<b) for sub
module addsub_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_flag
);

    logic [WIDTH:0] w_wide;

    // The extra top bit is the carry for add; for sub the zero-extended
    // difference wraps negative exactly when a<b, so the same bit is the borrow.
    always_comb begin
        w_wide = '0;
        if (i_sel == OP_SUB) begin
            w_wide = {1'b0, i_a} - {1'b0, i_b};
        end else begin
            w_wide = {1'b0, i_a} + {1'b0, i_b};
        end
    end

    assign o_result = w_wide[WIDTH-1:0];
    assign o_flag   = w_wide[WIDTH];

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester arbiter feeding one add/sub unit (IDLE/EXEC/RESP)
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : global accept enable
//   reqN_valid/ready    : request handshake, N=0,1 (ready combinational in IDLE)
//   reqN_sel/a/b        : operation (0=add, 1=sub) and operands
//   rsp_valid/ready     : response handshake
//   rsp_id/data/flag    : owner, result, carry/borrow
//   Macro ROUND_ROBIN_EN: alternate grants on contention; otherwise req0 has fixed priority.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_flag
);

    state_t           r_state;
    logic             r_sel;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_flag;

    logic             w_accept;
    logic             w_pick1;
    logic [WIDTH-1:0] w_result;
    logic             w_flag;

`ifdef ROUND_ROBIN_EN
    logic             r_last_grant;
    // On contention favour whichever requester did not win last time.
    assign w_pick1 = req1_valid & (~req0_valid | ~r_last_grant);
`else
    assign w_pick1 = req1_valid & ~req0_valid;
`endif

    // rst_n gates ready so nothing looks accepted while reset is held.
    assign w_accept   = rst_n & en & (r_state == IDLE) & (req0_valid | req1_valid);
    assign req0_ready = w_accept & ~w_pick1;
    assign req1_ready = w_accept &  w_pick1;

    addsub_unit #(.WIDTH(WIDTH)) u_unit (
        .i_sel    (r_sel),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_result),
        .o_flag   (w_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sel        <= OP_ADD;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_flag   <= 1'b0;
`ifdef ROUND_ROBIN_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sel   <= w_pick1 ? req1_sel : req0_sel;
                        r_a     <= w_pick1 ? req1_a   : req0_a;
                        r_b     <= w_pick1 ? req1_b   : req0_b;
                        r_id    <= w_pick1;
`ifdef ROUND_ROBIN_EN
                        r_last_grant <= w_pick1;
`endif
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_result;
                    r_rsp_flag  <= w_flag;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_flag  = r_rsp_flag;

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed scoreboard bench for addsub_arbiter
module tb_addsub_arbiter;
    import addsub_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         req0_valid, req0_ready, req0_sel;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sel;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_flag;
    logic [W-1:0] rsp_data;

    typedef struct packed {
        logic         id;
        logic         flag;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   arb_order[4];

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_sel   (req0_sel),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_sel   (req1_sel),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_flag   (rsp_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic sel,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] w;
        exp_t e;
        if (sel) w = {1'b0, a} - {1'b0, b};
        else     w = {1'b0, a} + {1'b0, b};
        e.id   = id;
        e.flag = w[W];
        e.data = w[W-1:0];
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_op(input logic v0, input logic s0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic v1, input logic s1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input logic exp_id, input bit drop_en, input int hold, input string tag);
        exp_t e;
        bit   done;
        @(negedge clk);
        en = 1'b1;
        req0_valid = v0; req0_sel = s0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_sel = s1; req1_a = a1; req1_b = b1;
        rsp_ready = (hold == 0);
        #1;
        chk({tag, " ready0"}, req0_ready, !exp_id);
        chk({tag, " ready1"}, req1_ready, exp_id);
        if (exp_id) sb.push_back(model(1'b1, s1, a1, b1));
        else        sb.push_back(model(1'b0, s0, a0, b0));
        done = 0;
        for (int cyc = 1; cyc <= 8 && !done; cyc++) begin
            @(negedge clk);
            if (drop_en) en = 1'b0;
            #1;
            if (!rsp_valid) begin
                chk({tag, " exec ready0"}, req0_ready, 1'b0);
                chk({tag, " exec ready1"}, req1_ready, 1'b0);
            end else begin
                chk({tag, " latency"}, cyc, 2);
                e = sb.pop_front();
                for (int h = 0; h <= hold; h++) begin
                    if (h == hold) rsp_ready = 1'b1;
                    chk({tag, " id"},   rsp_id,   e.id);
                    chk({tag, " data"}, rsp_data, e.data);
                    chk({tag, " flag"}, rsp_flag, e.flag);
                    chk({tag, " resp ready0"}, req0_ready, 1'b0);
                    chk({tag, " resp ready1"}, req1_ready, 1'b0);
                    if (h < hold) begin
                        @(negedge clk);
                        #1;
                        chk({tag, " held valid"}, rsp_valid, 1'b1);
                    end
                end
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) chk({tag, " response timeout"}, 0, 1);
        en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_sel = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b1; req1_sel = 1'b0; req1_a = '0; req1_b = '0;

        @(negedge clk);
        #1;
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset rsp_data", rsp_data, 4'h0);
        chk("reset rsp_flag", rsp_flag, 1'b0);
        chk("reset rsp_id", rsp_id, 1'b0);
        chk("reset ready0", req0_ready, 1'b0);
        chk("reset ready1", req1_ready, 1'b0);
        chk("reset state", dut.r_state, IDLE);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        run_op(1, 0, 4'b0001, 4'b0000, 0, 0, 4'h0, 4'h0, 0, 0, 0, "add0");
        run_op(0, 0, 4'h0, 4'h0, 1, 0, 4'b1000, 4'b1000, 1, 0, 0, "add1 carry");
        run_op(1, 1, 4'b0001, 4'b0100, 0, 0, 4'h0, 4'h0, 0, 0, 0, "sub borrow");
        run_op(1, 1, 4'b0100, 4'b0001, 0, 0, 4'h0, 4'h0, 0, 0, 0, "sub plain");

`ifdef ROUND_ROBIN_EN
        arb_order = '{0, 1, 0, 1};
`else
        arb_order = '{0, 0, 0, 0};
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_op(1, 0, 4'(i), 4'd1, 1, 1, 4'(15 - i), 4'd2, arb_order[i][0], 0, 0, "arb");
        end

        req0_valid = 1'b1; req0_sel = 1'b0; req0_a = 4'd3; req0_b = 4'd2;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("en low ready0", req0_ready, 1'b0);
        end
        run_op(1, 0, 4'd3, 4'd2, 0, 0, 4'h0, 4'h0, 0, 1, 0, "en drop");

        run_op(1, 1, 4'd7, 4'd9, 0, 0, 4'h0, 4'h0, 0, 0, 4, "backpressure");

        @(negedge clk);
        en = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_sel = 1'b0; req0_a = 4'd5; req0_b = 4'd6;
        #1;
        chk("midop accept", req0_ready, 1'b1);
        @(negedge clk);
        #1;
        chk("midop state exec", dut.r_state, EXEC);
        rst_n = 1'b0;
        #1;
        chk("midop rsp_valid", rsp_valid, 1'b0);
        chk("midop state idle", dut.r_state, IDLE);
        chk("midop ready0", req0_ready, 1'b0);
        sb.delete();
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("midop no response", rsp_valid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
